// File: rtl/best_metric_search.sv
// Minimum path-metric search over one trellis step: returns the smallest survivor
// metric, its state index, a normalization request and a step-length error flag.
module best_metric_search #(
  parameter int W_DIS    = 12,
  parameter int W_ST     = 6,
  parameter int N_STATES = 64,
  parameter int NORM_TH  = 2048
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             di_valid,
  output logic             di_ready,
  input  logic [W_DIS-1:0] di_dis,
  input  logic [W_ST-1:0]  di_state,
  input  logic             di_last,
  output logic             do_valid,
  input  logic             do_ready,
  output logic [W_DIS-1:0] do_dis,
  output logic [W_ST-1:0]  do_state,
  output logic             do_norm,
  output logic             do_err
);

  localparam int CW = W_ST + 1;
  localparam logic [CW-1:0]    CNT_LAST = CW'(N_STATES - 1);
  localparam logic [CW-1:0]    CNT_MAX  = CW'(N_STATES);
  localparam logic [W_DIS-1:0] TH       = W_DIS'(NORM_TH);

  // ACC: collecting a step; HOLD: a result is waiting for the traceback.
  typedef enum logic {ACC = 1'b0, HOLD = 1'b1} state_e;

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic             ovf_q;
  logic [W_DIS-1:0] min_dis_q;
  logic [W_ST-1:0]  min_st_q;
  logic             do_valid_q;
  logic [W_DIS-1:0] do_dis_q;
  logic [W_ST-1:0]  do_state_q;
  logic             do_norm_q;
  logic             do_err_q;

  logic             accept;
  logic             xfer;
  logic             first;
  logic             step_err;
  logic [W_DIS-1:0] min_dis_d;
  logic [W_ST-1:0]  min_st_d;

  // Input handshake: valid/ready, a beat moves on any edge where both are high.
  assign di_ready = (state_q == ACC) || do_ready;

  always_comb begin
    accept    = di_valid && di_ready;
    xfer      = do_valid_q && do_ready;
    first     = (cnt_q == '0) && !ovf_q;
    step_err  = ovf_q || (cnt_q != CNT_LAST);
    min_dis_d = min_dis_q;
    min_st_d  = min_st_q;
    // Strict less-than keeps the earliest candidate on ties.
    if (first || (di_dis < min_dis_q)) begin
      min_dis_d = di_dis;
      min_st_d  = di_state;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ACC;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      min_dis_q  <= '0;
      min_st_q   <= '0;
      do_valid_q <= 1'b0;
      do_dis_q   <= '0;
      do_state_q <= '0;
      do_norm_q  <= 1'b0;
      do_err_q   <= 1'b0;
    end else if (accept) begin
      if (di_last) begin
        state_q    <= HOLD;
        do_valid_q <= 1'b1;
        do_dis_q   <= min_dis_d;
        do_state_q <= min_st_d;
        do_norm_q  <= (min_dis_d >= TH);
        do_err_q   <= step_err;
        cnt_q      <= '0;
        ovf_q      <= 1'b0;
      end else begin
        state_q   <= ACC;
        min_dis_q <= min_dis_d;
        min_st_q  <= min_st_d;
        if (cnt_q == CNT_MAX) begin
          ovf_q <= 1'b1;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
        if (xfer) begin
          do_valid_q <= 1'b0;
        end
      end
    end else if (xfer) begin
      state_q    <= ACC;
      do_valid_q <= 1'b0;
    end
  end

  assign do_valid = do_valid_q;
  assign do_dis   = do_dis_q;
  assign do_state = do_state_q;
  assign do_norm  = do_norm_q;
  assign do_err   = do_err_q;

endmodule

// File: tb/tb_best_metric_search.sv
// Bench for best_metric_search: randomized steps against a queue-based reference
// model, with a decoupled monitor comparing each transferred result.
module tb_best_metric_search;

  localparam int W_DIS = 12;
  localparam int W_ST  = 6;
  localparam int N     = 64;
  localparam int TH    = 2048;
  localparam int EW    = W_DIS + W_ST + 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             di_valid = 1'b0;
  logic             di_ready;
  logic [W_DIS-1:0] di_dis = '0;
  logic [W_ST-1:0]  di_state = '0;
  logic             di_last = 1'b0;
  logic             do_valid;
  logic             do_ready = 1'b0;
  logic [W_DIS-1:0] do_dis;
  logic [W_ST-1:0]  do_state;
  logic             do_norm;
  logic             do_err;

  int n_checks = 0;
  int n_errors = 0;
  bit rdy_rand = 1'b0;

  logic [EW-1:0] exp_q[$];
  int unsigned   m_dis[$];
  int unsigned   m_st[$];

  best_metric_search #(.W_DIS(W_DIS), .W_ST(W_ST), .N_STATES(N), .NORM_TH(TH)) dut (
    .clk(clk), .rst_n(rst_n),
    .di_valid(di_valid), .di_ready(di_ready), .di_dis(di_dis),
    .di_state(di_state), .di_last(di_last),
    .do_valid(do_valid), .do_ready(do_ready), .do_dis(do_dis),
    .do_state(do_state), .do_norm(do_norm), .do_err(do_err)
  );

  // Clock and downstream back-pressure.
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rdy_rand) do_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic summary_and_fatal(input string why);
    n_errors++;
    $display("FAIL %s: timeout", why);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1, "timeout");
  endtask

  // Reference model: the minimum over the recorded step, earliest on ties.
  task automatic model_close();
    int unsigned md;
    int unsigned ms;
    bit          err;
    bit          norm;
    md = m_dis[0];
    ms = m_st[0];
    foreach (m_dis[i]) begin
      if (m_dis[i] < md) begin
        md = m_dis[i];
        ms = m_st[i];
      end
    end
    err  = (m_dis.size() != N);
    norm = (md >= TH);
    exp_q.push_back({W_DIS'(md), W_ST'(ms), norm, err});
    m_dis.delete();
    m_st.delete();
  endtask

  // Driver: present one beat, hold it until accepted, record it in the model.
  task automatic drive_beat(input int unsigned dis, input int unsigned st,
                            input bit last, input bit sync);
    bit acc;
    int waits;
    acc   = 1'b0;
    waits = 0;
    if (sync) @(negedge clk);
    di_valid = 1'b1;
    di_dis   = W_DIS'(dis);
    di_state = W_ST'(st);
    di_last  = last;
    while (!acc) begin
      #4;
      acc = di_ready;
      @(posedge clk);
      if (!acc) begin
        waits++;
        if (waits > 500) summary_and_fatal("drive_beat");
        @(negedge clk);
      end
    end
    m_dis.push_back(dis);
    m_st.push_back(st);
    if (last) model_close();
    #1;
    di_valid = 1'b0;
    di_dis   = W_DIS'($urandom);
    di_state = W_ST'($urandom);
    di_last  = 1'($urandom);
  endtask

  function automatic int unsigned metric(input int mode, input int i);
    case (mode)
      0:       return 100 + i;
      1:       return (i == 17 || i == 42) ? 5 : 'h3FF;
      2:       return (i == 9) ? 'h800 : 'hFFF;
      3:       return (i == 9) ? 'h7FF : 'hFFF;
      default: return $urandom_range(0, 4095);
    endcase
  endfunction

  task automatic send_step(input int n, input int mode);
    for (int i = 0; i < n; i++) begin
      drive_beat(metric(mode, i), (mode == 4) ? $urandom_range(0, 63) : (i % 64),
                 (i == n - 1), 1'b1);
    end
    check("latency_valid", {31'd0, do_valid}, 32'd1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_drain();
    int k;
    k = 0;
    while ((exp_q.size() != 0 || do_valid) && k < 400) begin
      @(negedge clk);
      k++;
    end
    check("drain", exp_q.size() + {31'd0, do_valid}, 32'd0);
  endtask

  // Monitor / scoreboard: compare on every result transfer, and check hold stability.
  logic [EW-1:0] held;
  bit            held_v = 1'b0;

  initial begin
    logic [EW-1:0] cur;
    logic [EW-1:0] e;
    forever begin
      @(negedge clk);
      #4;
      if (!rst_n || !do_valid) begin
        held_v = 1'b0;
      end else begin
        cur = {do_dis, do_state, do_norm, do_err};
        if (held_v) check("hold_stable", 32'(cur), 32'(held));
        if (do_ready) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_result: got %0h expected none", cur);
          end else begin
            e = exp_q.pop_front();
            check("result", 32'(cur), 32'(e));
          end
          held_v = 1'b0;
        end else begin
          held   = cur;
          held_v = 1'b1;
        end
      end
    end
  end

  initial begin
    int unsigned d0;
    int unsigned s0;
    int          n;

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_do_valid", {31'd0, do_valid}, 32'd0);
    check("rst_do_dis", 32'(do_dis), 32'd0);
    check("rst_do_state", 32'(do_state), 32'd0);
    check("rst_do_norm_err", {30'd0, do_norm, do_err}, 32'd0);
    check("rst_di_ready", {31'd0, di_ready}, 32'd1);
    @(negedge clk);
    rst_n    = 1'b1;
    do_ready = 1'b1;

    // Ascending metrics: minimum is state 0 with metric 100.
    send_step(64, 0);
    check("asc_dis", 32'(do_dis), 32'd100);
    check("asc_state", 32'(do_state), 32'd0);
    check("asc_norm_err", {30'd0, do_norm, do_err}, 32'd0);

    rdy_rand = 1'b1;
    send_step(64, 1);
    send_step(64, 2);
    send_step(64, 3);
    send_step(10, 0);
    send_step(71, 4);
    send_step(64, 4);

    // Back-pressure: result held, next beat stalls, then enters as beat 0.
    wait_drain();
    @(negedge clk);
    rdy_rand = 1'b0;
    do_ready = 1'b0;
    send_step(64, 4);
    @(negedge clk);
    d0 = $urandom_range(0, 4095);
    s0 = $urandom_range(0, 63);
    di_valid = 1'b1;
    di_dis   = W_DIS'(d0);
    di_state = W_ST'(s0);
    di_last  = 1'b0;
    repeat (5) begin
      #4;
      check("stall_di_ready", {31'd0, di_ready}, 32'd0);
      check("stall_do_valid", {31'd0, do_valid}, 32'd1);
      @(negedge clk);
    end
    do_ready = 1'b1;
    drive_beat(d0, s0, 1'b0, 1'b0);
    for (int i = 1; i < 64; i++) begin
      drive_beat($urandom_range(0, 4095), $urandom_range(0, 63), (i == 63), 1'b1);
    end
    rdy_rand = 1'b1;

    // Reset in the middle of a step discards the partial step.
    wait_drain();
    for (int i = 0; i < 30; i++) begin
      drive_beat($urandom_range(0, 4095), i, 1'b0, 1'b1);
    end
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_outputs", {20'd0, do_valid, do_norm, do_err, 3'd0, do_state}, 32'd0);
    check("mid_rst_dis", 32'(do_dis), 32'd0);
    check("mid_rst_di_ready", {31'd0, di_ready}, 32'd1);
    m_dis.delete();
    m_st.delete();
    @(negedge clk);
    rst_n = 1'b1;
    send_step(64, 4);

    // Random steps: mostly full length, some short (incl. one-beat) and long.
    for (int s = 0; s < 14; s++) begin
      case ($urandom_range(0, 3))
        0:       n = $urandom_range(1, 3);
        1:       n = $urandom_range(65, 70);
        default: n = 64;
      endcase
      idle($urandom_range(0, 2));
      send_step(n, 4);
    end

    @(negedge clk);
    rdy_rand = 1'b0;
    do_ready = 1'b1;
    wait_drain();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/best_metric_search.md
BEST_METRIC_SEARCH -- requirements
Module: best_metric_search

Interface
Parameters:
REQ-001 W_DIS, 12, path-metric width; must match the survivor-select stage output width.
REQ-002 W_ST, 6, state-index width, giving 64 trellis states.
REQ-003 N_STATES, 64, candidates per trellis step.
REQ-004 NORM_TH, 2048, minimum-metric threshold at which normalization is requested.

Ports (name, direction, width, meaning):
REQ-005 clk  in  1  single clock; all logic is rising-edge.
REQ-006 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-007 di_valid  in  1  candidate valid.
REQ-008 di_ready  out  1  block accepts a candidate this cycle.
REQ-009 di_dis  in  W_DIS  survivor path metric from the survivor-select stage, unsigned.
REQ-010 di_state  in  W_ST  survivor state index paired with di_dis.
REQ-011 di_last  in  1  marks the final candidate of a trellis step.
REQ-012 do_valid  out  1  step result valid.
REQ-013 do_ready  in  1  downstream (traceback) accepts the result.
REQ-014 do_dis  out  W_DIS  minimum metric of the step.
REQ-015 do_state  out  W_ST  state index owning that minimum.
REQ-016 do_norm  out  1  do_dis >= NORM_TH; the ACS subtracts do_dis next step.
REQ-017 do_err  out  1  the step did not contain exactly N_STATES candidates.

Function
REQ-018 A beat is accepted when di_valid and di_ready are both 1 on a clk rising edge; a result transfers when do_valid and do_ready are both 1.
REQ-019 di_ready shall equal (not do_valid) or do_ready, combinationally; it has no other dependency.
REQ-020 The FSM has two states: ACC (collecting a step) and HOLD (result pending); reset enters ACC.
REQ-021 The first accepted beat of a step shall load the running minimum (metric, state) unconditionally.
REQ-022 Each later accepted beat shall replace the running minimum only if di_dis < running metric, compared as unsigned.
REQ-023 Ties shall keep the earlier candidate, i.e. the lowest arrival order.
REQ-024 A beat counter (W_ST+1 bits) shall clear at step start and increment on each accepted beat, saturating at N_STATES.
REQ-025 An accepted beat with di_last=1 shall close the step.
REQ-026 On the edge that closes the step, the final minimum (including that beat) shall load do_dis/do_state and do_valid shall go to 1, giving one-cycle latency from the last beat to the result; the FSM enters HOLD.
REQ-027 do_norm and do_err shall be registered together with do_dis and held stable while do_valid=1.
REQ-028 do_err=1 iff the closed step held a beat count other than N_STATES; this covers short steps and steps with more than N_STATES beats (saturated count plus an overflow flag).
REQ-029 In HOLD, do_dis, do_state, do_norm and do_err shall not change until the result transfers.
REQ-030 A result transfer with no accepted beat in the same cycle shall clear do_valid and return the FSM to ACC.
REQ-031 A result transfer together with an accepted beat in the same cycle shall clear the old result and treat that beat as the first beat of the new step; no beat is lost.
REQ-032 A result transfer together with an accepted beat that has di_last=1 in the same cycle shall close a one-beat step: do_valid stays 1, a new result loads with do_err=1, and the FSM stays in HOLD.
REQ-033 di_dis, di_state and di_last shall be ignored when a beat is not accepted.
REQ-034 The block shall hold no combinational path from di_valid or di_dis to any do_* output.

Reset
REQ-035 When rst_n=0, the block shall asynchronously clear do_valid, do_dis, do_state, do_norm, do_err, the beat counter and the running minimum, and set the FSM to ACC.
REQ-036 While rst_n=0, di_ready shall read 1.
REQ-037 Reset asserted mid-step shall discard the partial step; after release, the next accepted beat is a first beat.
REQ-038 Deassertion of rst_n is synchronous to clk, supplied externally.

Verification
REQ-039 64 beats with metrics 100+i for state i, last on i=63, do_ready=1 -> one cycle after the last beat: do_valid=1, do_dis=100, do_state=0, do_norm=0, do_err=0.
REQ-040 64 beats all with metric 0x3FF except states 17 and 42 at metric 5 -> do_state=17, do_dis=5 (tie keeps the earlier candidate).
REQ-041 64 beats with minimum metric 0x800 at state 9 -> do_norm=1, do_dis=0x800; with minimum 0x7FF -> do_norm=0.
REQ-042 Step with di_last on the 10th beat -> do_err=1; step with 70 beats then last -> do_err=1; next step of exactly 64 beats -> do_err=0.
REQ-043 Result held with do_ready=0 for 5 cycles while di_valid=1 -> di_ready=0, outputs stable, no beat accepted; then do_ready=1 -> that cycle's beat is accepted as beat 0 of the new step.
REQ-044 rst_n pulsed low after 30 beats of a step -> all outputs 0 immediately; a following full 64-beat step yields the correct minimum with do_err=0.
